// File: rtl/spart_pkg.sv
// Shared SPART definitions: frame geometry and receive FSM encoding.
// Also used by the transmitter and the baud generator.
package spart_pkg;

  localparam int unsigned OVERSAMPLE = 16;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

endpackage

// File: rtl/spart_sync2.sv
// Two-flop synchronizer for asynchronous inputs; resets to all ones
// so that an idle-high line reads idle coming out of reset.
module spart_sync2 #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= '1;
      r_sync <= '1;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: 16x oversampled 8N1 framing with data-available,
// framing-error and overrun flags for the bus interface.
module spart_rx
  import spart_pkg::*;
#(
  parameter int unsigned DATA_BITS  = spart_pkg::DATA_BITS,
  parameter int unsigned OVERSAMPLE = spart_pkg::OVERSAMPLE
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 enable,
  input  logic                 rxd,
  input  logic                 rd_ack,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rda,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int unsigned TW = $clog2(OVERSAMPLE);
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic                 w_rxd_s;
  rx_state_t            r_state;
  logic [TW-1:0]        r_tick;
  logic [BW-1:0]        r_bit_idx;
  logic [DATA_BITS-1:0] r_shift;

  spart_sync2 #(.WIDTH(1)) u_sync (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_d     (rxd),
    .o_q     (w_rxd_s)
  );

  // The read-acknowledge clear comes first so a same-cycle STOP load overrides it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= IDLE;
      r_tick    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      rx_data   <= '0;
      rda       <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (rd_ack && rda) begin
        rda       <= 1'b0;
        frame_err <= 1'b0;
        overrun   <= 1'b0;
      end
      if (enable) begin
        case (r_state)
          IDLE: begin
            if (!w_rxd_s) begin
              r_state <= START;
              r_tick  <= '0;
            end
          end
          START: begin
            if (r_tick == TICK_HALF) begin
              r_tick <= '0;
              if (!w_rxd_s) begin
                r_state   <= DATA;
                r_bit_idx <= '0;
              end else begin
                r_state <= IDLE;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          DATA: begin
            if (r_tick == TICK_LAST) begin
              r_tick    <= '0;
              r_shift   <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
              r_bit_idx <= r_bit_idx + 1'b1;
              if (r_bit_idx == BIT_LAST) begin
                r_state <= STOP;
              end
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          STOP: begin
            // Sampled at mid stop bit, so IDLE is back half a bit early.
            if (r_tick == TICK_LAST) begin
              r_tick    <= '0;
              rx_data   <= r_shift;
              rda       <= 1'b1;
              frame_err <= ~w_rxd_s;
              overrun   <= rda && !rd_ack;
              r_state   <= IDLE;
            end else begin
              r_tick <= r_tick + 1'b1;
            end
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spart_rx.sv
// Scoreboard bench for spart_rx: directed frames push expected bytes,
// a monitor pops and compares on every new byte presentation.
module tb_spart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       enable = 1'b0;
  logic       rxd = 1'b1;
  logic       rd_ack = 1'b0;
  logic [7:0] rx_data;
  logic       rda;
  logic       frame_err;
  logic       overrun;

  typedef struct packed {
    logic [7:0] d;
    logic       fe;
    logic       ov;
  } exp_t;

  exp_t        exp_q[$];
  int unsigned n_vec = 0;
  int unsigned n_err = 0;
  bit          en_hold = 1'b0;
  int unsigned ecnt = 0;

  always #5 clk = ~clk;

  spart_rx #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .rxd       (rxd),
    .rd_ack    (rd_ack),
    .rx_data   (rx_data),
    .rda       (rda),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  // enable: one pulse every 10 clk, or held high when en_hold is set
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (en_hold) begin
        enable = 1'b1;
      end else begin
        enable = (ecnt == 0);
        ecnt   = (ecnt == 9) ? 0 : ecnt + 1;
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_vec++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic wait_clk(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic push(input logic [7:0] d, input logic fe, input logic ov);
    exp_t e;
    e.d  = d;
    e.fe = fe;
    e.ov = ov;
    exp_q.push_back(e);
  endtask

  task automatic send(input logic [7:0] d, input logic stop_v,
                      input int unsigned cpb, input int unsigned stop_clks);
    rxd = 1'b0;
    wait_clk(cpb);
    for (int unsigned i = 0; i < 8; i++) begin
      rxd = d[i];
      wait_clk(cpb);
    end
    rxd = stop_v;
    wait_clk(stop_clks);
    rxd = 1'b1;
  endtask

  task automatic ack();
    rd_ack = 1'b1;
    wait_clk(1);
    rd_ack = 1'b0;
  endtask

  task automatic drain(input string name);
    int unsigned t = 0;
    while (exp_q.size() != 0 && t < 4000) begin
      wait_clk(1);
      t++;
    end
    if (exp_q.size() != 0) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: timeout, got no byte for %0d expected frame(s)", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: a presentation is rda rising, or a new byte replacing an unread one
  initial begin
    logic       prev_rda = 1'b0;
    logic [7:0] prev_data = 8'h00;
    exp_t       e;
    forever begin
      @(negedge clk);
      if (rst === 1'b1 && rda === 1'b1 && (!prev_rda || rx_data != prev_data)) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected_byte: got data %02h fe %0b ov %0b, required none",
                   rx_data, frame_err, overrun);
        end else begin
          e = exp_q.pop_front();
          check("frame {data,fe,ov}", {22'b0, rx_data, frame_err, overrun},
                {22'b0, e.d, e.fe, e.ov});
        end
      end
      prev_rda  = rda;
      prev_data = rx_data;
    end
  end

  initial begin
    repeat (60000) @(posedge clk);
    $display("FAIL watchdog: got no end of test, required completion within 60000 clk");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b0;
    wait_clk(3);
    check("reset rx_data", rx_data, 0);
    check("reset rda", rda, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    rst = 1'b1;
    wait_clk(20);

    // 0xA5: load lands 82..92 clk into the stop bit
    push(8'hA5, 1'b0, 1'b0);
    fork
      send(8'hA5, 1'b1, 160, 160);
      begin
        wait_clk(1440 + 60);
        check("a5 rda before mid-stop", rda, 0);
        wait_clk(50);
        check("a5 rda after mid-stop", rda, 1);
      end
    join
    drain("a5");
    ack();
    check("a5 rda after ack", rda, 0);
    check("a5 rx_data held", rx_data, 8'hA5);

    // start-bit glitch of 4 ticks
    wait_clk(50);
    rxd = 1'b0;
    wait_clk(40);
    rxd = 1'b1;
    wait_clk(2500);
    check("glitch rda", rda, 0);
    check("glitch rx_data", rx_data, 8'hA5);

    // 0x3C with stop bit low
    push(8'h3C, 1'b1, 1'b0);
    send(8'h3C, 1'b0, 160, 160);
    drain("3c");
    wait_clk(300);
    ack();
    check("3c frame_err after ack", frame_err, 0);
    check("3c rda after ack", rda, 0);

    // overrun: 0x11 then 0x22 unread
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b1);
    send(8'h11, 1'b1, 160, 160);
    send(8'h22, 1'b1, 160, 160);
    drain("overrun");
    ack();
    check("overrun cleared by ack", overrun, 0);
    check("overrun rda after ack", rda, 0);

    // enable held high: exact timing, rd_ack in the clk of the second load
    wait_clk(50);
    en_hold = 1'b1;
    wait_clk(20);
    push(8'h11, 1'b0, 1'b0);
    push(8'h22, 1'b0, 1'b0);
    fork
      begin
        send(8'h11, 1'b1, 16, 16);
        send(8'h22, 1'b1, 16, 16);
      end
      begin
        wait_clk(154);
        check("en_high rda one clk early", rda, 0);
        wait_clk(1);
        check("en_high rda at 152 ticks", rda, 1);
        wait_clk(159);
        rd_ack = 1'b1;
        wait_clk(1);
        rd_ack = 1'b0;
        check("load beats ack rda", rda, 1);
        check("load beats ack overrun", overrun, 0);
      end
    join
    drain("en_high");
    ack();
    en_hold = 1'b0;
    wait_clk(50);

    // reset in the middle of 0x5A data bits
    rxd = 1'b0;
    wait_clk(160);
    rxd = 1'b0;
    wait_clk(160);
    rxd = 1'b1;
    wait_clk(160);
    rxd = 1'b0;
    wait_clk(80);
    rst = 1'b0;
    wait_clk(2);
    check("midreset rx_data", rx_data, 0);
    check("midreset rda", rda, 0);
    check("midreset frame_err", frame_err, 0);
    check("midreset overrun", overrun, 0);
    rxd = 1'b1;
    wait_clk(5);
    rst = 1'b1;
    wait_clk(2000);
    check("no partial frame", rda, 0);
    push(8'h81, 1'b0, 1'b0);
    send(8'h81, 1'b1, 160, 160);
    drain("81");
    ack();

    // back-to-back 0x00, 0xFF with minimum stop, read between
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    fork
      begin
        send(8'h00, 1'b1, 160, 160);
        send(8'hFF, 1'b1, 160, 160);
      end
      begin
        wait_clk(1440 + 120);
        ack();
      end
    join
    drain("b2b");
    ack();
    check("b2b rda after final ack", rda, 0);

    wait_clk(500);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
